eip_sequencer: RTL and testbench

Single-clock instruction-cycle controller that owns the EIP and steps through the fetch, decode, execute and update phases.

---
 rtl/eip_pkg.sv | 23 ++
 rtl/eip_sequencer_if.sv | 21 ++
 rtl/eip_next_calc.sv | 11 +
 rtl/eip_sequencer.sv | 116 +++++++++++
 tb/tb_eip_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/eip_pkg.sv
// Shared definitions for the EIP sequencer: state encoding, default
// reset vector / length limit, and the instruction-length legality test.
package eip_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } eip_state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0050;
    localparam int          MAX_OPE_DEF      = 6;

    // Legal lengths are 1..max_ope bytes.
    function automatic logic len_legal(input logic [3:0] len, input int max_ope);
        return (len != 4'd0) && ({28'd0, len} <= 32'(max_ope));
    endfunction

endpackage

// File: rtl/eip_sequencer_if.sv
// Memory / decoder / execute handshake bundle seen by the EIP sequencer.
interface eip_sequencer_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [3:0]  num_of_ope;
    logic        exec_start;
    logic        exec_done;
    logic        jump_req;
    logic [31:0] jump_target;

    modport master (
        output fetch_req, fetch_addr, exec_start,
        input  fetch_ack, num_of_ope, exec_done, jump_req, jump_target
    );

    modport slave (
        input  fetch_req, fetch_addr, exec_start,
        output fetch_ack, num_of_ope, exec_done, jump_req, jump_target
    );
endinterface

// File: rtl/eip_next_calc.sv
// Next-EIP selection: jump target or sequential advance by the latched length.
module eip_next_calc (
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic [31:0] eip,
    input  logic [3:0]  len_q,
    output logic [31:0] next_eip
);
    // Sequential advance wraps modulo 2^32.
    assign next_eip = jump_req ? jump_target : eip + {28'd0, len_q};
endmodule

// File: rtl/eip_sequencer.sv
// Instruction-cycle controller and sole owner of the EIP.
// Optional fetch_ack timeout enabled by defining FETCH_TIMEOUT_EN.
module eip_sequencer
    import eip_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          MAX_OPE      = MAX_OPE_DEF
`ifdef FETCH_TIMEOUT_EN
   ,parameter int          TIMEOUT_CYC  = 15
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    eip_sequencer_if.master        bus,
    input  logic                   halt_req,
    output logic [31:0]            eip,
    output logic [2:0]             state,
    output logic                   halted,
    output logic                   fault
);

    eip_state_e  st;
    logic [3:0]  len_q;
    logic [31:0] next_eip;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  to_cnt;
`endif

    eip_next_calc u_next (
        .jump_req    (bus.jump_req),
        .jump_target (bus.jump_target),
        .eip         (eip),
        .len_q       (len_q),
        .next_eip    (next_eip)
    );

    assign bus.fetch_addr = eip;
    assign state          = st;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            eip            <= RESET_VECTOR;
            st             <= S_FETCH;
            bus.fetch_req  <= 1'b0;
            bus.exec_start <= 1'b0;
            halted         <= 1'b0;
            fault          <= 1'b0;
            len_q          <= 4'd0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt         <= 4'd0;
`endif
        end else begin
            bus.exec_start <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt         <= 4'd0;
`endif
            case (st)
                // After reset fetch_req is still low here; raise it first so an
                // ack left over from before reset is never taken.
                S_FETCH: begin
                    if (!bus.fetch_req) begin
                        bus.fetch_req <= 1'b1;
                    end else if (bus.fetch_ack) begin
                        bus.fetch_req <= 1'b0;
                        st            <= S_DECODE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_cnt == 4'(TIMEOUT_CYC - 1)) begin
                        bus.fetch_req <= 1'b0;
                        fault         <= 1'b1;
                        st            <= S_FAULT;
                    end else begin
                        to_cnt <= to_cnt + 4'd1;
                    end
`endif
                end
                S_DECODE: begin
                    len_q <= bus.num_of_ope;
                    if (len_legal(bus.num_of_ope, MAX_OPE)) begin
                        bus.exec_start <= 1'b1;
                        st             <= S_EXEC;
                    end else begin
                        fault <= 1'b1;
                        st    <= S_FAULT;
                    end
                end
                S_EXEC: st <= S_WAIT;
                S_WAIT: if (bus.exec_done) st <= S_UPDATE;
                S_UPDATE: begin
                    eip <= next_eip;
                    if (halt_req) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else begin
                        bus.fetch_req <= 1'b1;
                        st            <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!halt_req) begin
                        halted        <= 1'b0;
                        bus.fetch_req <= 1'b1;
                        st            <= S_FETCH;
                    end
                end
                S_FAULT: ;
                default: begin
                    fault <= 1'b1;
                    st    <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eip_sequencer.sv
// Scoreboard bench for eip_sequencer: expected fetch addresses are queued by
// the stimulus and popped by a monitor on every fetch_req rise.
module tb_eip_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] eip;
    logic [2:0]  state;
    logic        halted;
    logic        fault;

    eip_sequencer_if bus ();

    eip_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .halt_req (halt_req),
        .eip      (eip),
        .state    (state),
        .halted   (halted),
        .fault    (fault)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    int          es_cnt = 0;
    logic        fr_prev = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count exec_start pulses and score every new fetch request.
    always @(negedge clock) begin
        if (exec_start_hi()) es_cnt++;
        if (bus.fetch_req === 1'b1 && fr_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fetch_unexpected: got %h expected none", bus.fetch_addr);
            end else begin
                chk("fetch_addr", bus.fetch_addr, exp_q.pop_front());
            end
        end
        fr_prev = bus.fetch_req;
    end

    function automatic logic exec_start_hi();
        return bus.exec_start === 1'b1;
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.fetch_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL fetch_wait: got no fetch_req expected one within 40 cycles");
        end
    endtask

    task automatic apply_reset();
        chk("pending_fetches", exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("rst_eip", eip, 32'h0000_0050);
        chk("rst_state", state, 0);
        chk("rst_fetch_req", bus.fetch_req, 0);
        chk("rst_exec_start", bus.exec_start, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        step();
        exp_q.push_back(32'h0000_0050);
        reset = 1'b1;
    endtask

    task automatic do_instr(input logic [3:0] len, input logic jmp, input logic [31:0] tgt,
                            input logic hlt, input int ack_dly, input logic [31:0] exp_eip);
        bit ok;
        int es0;
        wait_fetch(ok);
        if (!ok) return;
        es0 = es_cnt;
        repeat (ack_dly) step();
        bus.fetch_ack   = 1'b1;
        bus.num_of_ope  = len;
        bus.jump_req    = jmp;
        bus.jump_target = tgt;
        halt_req        = hlt;
        if (!hlt) exp_q.push_back(exp_eip);
        step();                               // DECODE
        bus.fetch_ack = 1'b0;
        chk("decode_fetch_req", bus.fetch_req, 0);
        step();                               // EXEC
        chk("exec_start", bus.exec_start, 1);
        step();                               // WAIT
        bus.exec_done = 1'b1;
        step();                               // UPDATE
        bus.exec_done = 1'b0;
        chk("update_state", state, 4);
        step();
        chk("eip", eip, exp_eip);
        chk("halted", halted, hlt);
        chk("exec_pulses", es_cnt - es0, 1);
        bus.jump_req = 1'b0;
    endtask

    task automatic do_fault(input logic [3:0] len, input logic [31:0] exp_eip);
        bit ok;
        wait_fetch(ok);
        if (!ok) return;
        bus.fetch_ack  = 1'b1;
        bus.num_of_ope = len;
        step();
        bus.fetch_ack = 1'b0;
        step();
        chk("fault_state", state, 6);
        chk("fault_flag", fault, 1);
        chk("fault_eip", eip, exp_eip);
        chk("fault_exec_start", bus.exec_start, 0);
        repeat (5) step();
        chk("fault_no_fetch", bus.fetch_req, 0);
        chk("fault_sticky", state, 6);
        apply_reset();
    endtask

    logic [3:0]  len_tab [5] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    logic [31:0] eip_tab [5] = '{32'h51, 32'h53, 32'h57, 32'h5C, 32'h62};

    initial begin
        bit ok;
        bus.fetch_ack   = 1'b0;
        bus.num_of_ope  = 4'd0;
        bus.exec_done   = 1'b0;
        bus.jump_req    = 1'b0;
        bus.jump_target = 32'd0;
        repeat (3) step();
        apply_reset();

        // First instruction, slow ack; next fetch must be at 0x53.
        do_instr(4'd3, 1'b0, 32'd0, 1'b0, 2, 32'h53);

        apply_reset();
        for (int i = 0; i < 5; i++)
            do_instr(len_tab[i], 1'b0, 32'd0, 1'b0, 1, eip_tab[i]);

        do_instr(4'd2, 1'b1, 32'h27, 1'b0, 1, 32'h27);

        do_fault(4'd0, 32'h27);
        do_fault(4'd7, 32'h50);

        // Halt after a length-2 instruction, then resume.
        do_instr(4'd2, 1'b0, 32'd0, 1'b1, 1, 32'h52);
        chk("halt_state", state, 5);
        repeat (3) step();
        chk("halt_no_fetch", bus.fetch_req, 0);
        chk("halt_eip_frozen", eip, 32'h52);
        exp_q.push_back(32'h52);
        halt_req = 1'b0;
        step();
        chk("resume_halted", halted, 0);
        chk("resume_state", state, 0);

        // Jump and halt together: jump applied, then HALT.
        do_instr(4'd1, 1'b1, 32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFE);
        chk("jmp_halt_state", state, 5);
        exp_q.push_back(32'hFFFF_FFFE);
        halt_req = 1'b0;
        step();

        // Wrap past 2^32.
        do_instr(4'd3, 1'b0, 32'd0, 1'b0, 1, 32'h1);

        // Reset asserted mid-WAIT: eip returns to the vector before any edge.
        wait_fetch(ok);
        if (ok) begin
            bus.fetch_ack  = 1'b1;
            bus.num_of_ope = 4'd4;
            step();
            bus.fetch_ack = 1'b0;
            step();
            step();
            step();
            chk("wait_state", state, 3);
            chk("wait_eip", eip, 32'h1);
            #2;
        end
        apply_reset();
        do_instr(4'd1, 1'b0, 32'd0, 1'b0, 0, 32'h51);

`ifdef FETCH_TIMEOUT_EN
        apply_reset();
        wait_fetch(ok);
        repeat (16) step();
        chk("timeout_fault", fault, 1);
        chk("timeout_state", state, 6);
        apply_reset();
        do_instr(4'd2, 1'b0, 32'd0, 1'b0, 0, 32'h52);
`endif

        repeat (2) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
